// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker: strips and verifies a trailing CRC-8 (poly 0x07) byte per frame
module crc8_frame_checker #(
  parameter int MAX_LEN = 255,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [15:0]      err_count
);
  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       crc_q, crc_d, hold_q, hold_d, m_data_q, m_data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, frame_len_q, frame_len_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d, done_q, done_d;
  logic             crc_ok_q, crc_ok_d, len_err_q, len_err_d, bad;
  logic [15:0]      err_q, err_d;
  logic [7:0]       residue;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  assign residue   = crc8_step(crc_q, s_data);
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign len_err   = len_err_q;
  assign frame_len = frame_len_q;
  assign err_count = err_q;

  // next-state: holdback forwarding, CRC accumulation and per-frame status
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    done_d      = 1'b0;
    crc_ok_d    = crc_ok_q;
    len_err_d   = len_err_q;
    frame_len_d = frame_len_q;
    bad         = 1'b0;
    if (abort) begin
      state_d = IDLE;
      crc_d   = 8'h00;
      cnt_d   = '0;
      hold_d  = 8'h00;
    end else if (s_valid) begin
      case (state_q)
        IDLE: begin
          if (s_last) begin
            done_d      = 1'b1;
            crc_ok_d    = 1'b0;
            len_err_d   = 1'b1;
            frame_len_d = '0;
            bad         = 1'b1;
          end else begin
            hold_d  = s_data;
            crc_d   = crc8_step(8'h00, s_data);
            cnt_d   = LEN_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          m_valid_d = 1'b1;
          m_data_d  = hold_q;
          if (cnt_q == LEN_W'(MAX_LEN)) begin
            m_last_d    = 1'b1;
            done_d      = 1'b1;
            crc_ok_d    = 1'b0;
            len_err_d   = 1'b1;
            frame_len_d = LEN_W'(MAX_LEN);
            bad         = 1'b1;
            crc_d       = 8'h00;
            cnt_d       = '0;
            state_d     = s_last ? IDLE : DROP;
          end else if (s_last) begin
            m_last_d    = 1'b1;
            done_d      = 1'b1;
            crc_ok_d    = residue == 8'h00;
            len_err_d   = 1'b0;
            frame_len_d = cnt_q;
            bad         = residue != 8'h00;
            crc_d       = 8'h00;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            hold_d = s_data;
            crc_d  = residue;
            cnt_d  = cnt_q + LEN_W'(1);
          end
        end
        DROP: state_d = s_last ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end
    err_d = (bad && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      crc_q       <= 8'h00;
      cnt_q       <= '0;
      hold_q      <= 8'h00;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
      frame_len_q <= '0;
      err_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
      crc_ok_q    <= crc_ok_d;
      len_err_q   <= len_err_d;
      frame_len_q <= frame_len_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb_crc8_frame_checker: directed checks of CRC-8 frame stripping and status
module tb_crc8_frame_checker;
  logic       clk = 1'b0;
  logic       reset = 1'b1, abort = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [7:0] m_data, m_data4, frame_len, frame_len4;
  logic       m_valid, m_last, done, crc_ok, len_err;
  logic       m_valid4, m_last4, done4, crc_ok4, len_err4;
  logic [15:0] err_count, err_count4;
  int tests = 0, fails = 0;
  logic [7:0] good [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};

  crc8_frame_checker dut (
    .clk(clk), .reset(reset), .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .done(done), .crc_ok(crc_ok),
    .len_err(len_err), .frame_len(frame_len), .err_count(err_count)
  );

  crc8_frame_checker #(.MAX_LEN(4), .LEN_W(8)) dut4 (
    .clk(clk), .reset(reset), .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .m_data(m_data4), .m_valid(m_valid4), .m_last(m_last4), .done(done4), .crc_ok(crc_ok4),
    .len_err(len_err4), .frame_len(frame_len4), .err_count(err_count4)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] d, input logic l);
    s_data = d;
    s_valid = 1'b1;
    s_last = l;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({m_data, m_valid, m_last, done, crc_ok, len_err, frame_len, err_count} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp 0", {m_data, m_valid, m_last, done, crc_ok, len_err, frame_len, err_count});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame;
    for (int i = 0; i < 10; i++) begin
      send(good[i], i == 9);
      tests++;
      if ({m_valid, m_last, done} !== {i > 0, i == 9, i == 9}) begin
        fails++;
        $display("FAIL good_flags i=%0d got %b exp %b", i, {m_valid, m_last, done}, {i > 0, i == 9, i == 9});
      end
      if (i > 0) begin
        tests++;
        if (m_data !== good[i-1]) begin
          fails++;
          $display("FAIL good_data i=%0d got %h exp %h", i, m_data, good[i-1]);
        end
      end
    end
    tests++;
    if ({crc_ok, len_err, frame_len, err_count} !== {1'b1, 1'b0, 8'd9, 16'd0}) begin
      fails++;
      $display("FAIL good_status got ok=%b le=%b len=%0d err=%0d exp 1 0 9 0", crc_ok, len_err, frame_len, err_count);
    end
  endtask

  task automatic test_back_to_back;
    send(8'h01, 1'b0);
    tests++;
    if ({m_valid, done} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_first got %b exp 00", {m_valid, done});
    end
    send(8'h07, 1'b1);
    tests++;
    if ({m_valid, m_last, done, m_data, crc_ok, len_err, frame_len} !== {3'b111, 8'h01, 1'b1, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL b2b_frame1 got v=%b l=%b d=%b data=%h ok=%b le=%b len=%0d exp 1 1 1 01 1 0 1",
               m_valid, m_last, done, m_data, crc_ok, len_err, frame_len);
    end
    send(8'h01, 1'b0);
    tests++;
    if ({m_valid, done, crc_ok, frame_len} !== {2'b00, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL b2b_hold got v=%b d=%b ok=%b len=%0d exp 0 0 1 1", m_valid, done, crc_ok, frame_len);
    end
    send(8'h06, 1'b1);
    tests++;
    if ({m_valid, done, m_data, crc_ok, len_err, frame_len, err_count} !== {2'b11, 8'h01, 1'b0, 1'b0, 8'd1, 16'd1}) begin
      fails++;
      $display("FAIL b2b_frame2 got v=%b d=%b data=%h ok=%b le=%b len=%0d err=%0d exp 1 1 01 0 0 1 1",
               m_valid, done, m_data, crc_ok, len_err, frame_len, err_count);
    end
  endtask

  task automatic test_runt;
    @(posedge clk);
    #1;
    send(8'h55, 1'b1);
    tests++;
    if ({m_valid, done, crc_ok, len_err, frame_len, err_count} !== {2'b01, 1'b0, 1'b1, 8'd0, 16'd2}) begin
      fails++;
      $display("FAIL runt got v=%b d=%b ok=%b le=%b len=%0d err=%0d exp 0 1 0 1 0 2",
               m_valid, done, crc_ok, len_err, frame_len, err_count);
    end
  endtask

  task automatic test_abort;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    tests++;
    if ({m_valid, m_data} !== {1'b1, 8'h31}) begin
      fails++;
      $display("FAIL abort_pre1 got v=%b data=%h exp 1 31", m_valid, m_data);
    end
    send(8'h33, 1'b0);
    tests++;
    if ({m_valid, m_data} !== {1'b1, 8'h32}) begin
      fails++;
      $display("FAIL abort_pre2 got v=%b data=%h exp 1 32", m_valid, m_data);
    end
    abort = 1'b1;
    send(8'h34, 1'b0);
    abort = 1'b0;
    tests++;
    if ({m_valid, done} !== 2'b00) begin
      fails++;
      $display("FAIL abort_cycle got v=%b d=%b exp 0 0", m_valid, done);
    end
    send(8'h01, 1'b0);
    tests++;
    if ({m_valid, done} !== 2'b00) begin
      fails++;
      $display("FAIL abort_restart got v=%b d=%b exp 0 0", m_valid, done);
    end
    send(8'h07, 1'b1);
    tests++;
    if ({m_valid, m_last, done, m_data, crc_ok, len_err, frame_len, err_count} !== {3'b111, 8'h01, 2'b10, 8'd1, 16'd2}) begin
      fails++;
      $display("FAIL abort_next got v=%b l=%b d=%b data=%h ok=%b le=%b len=%0d err=%0d exp 1 1 1 01 1 0 1 2",
               m_valid, m_last, done, m_data, crc_ok, len_err, frame_len, err_count);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      b = 8'hA0 + 8'(i);
      send(b, i == 6);
      tests++;
      if ({m_valid4, m_last4, done4} !== {i >= 1 && i <= 4, i == 4, i == 4}) begin
        fails++;
        $display("FAIL ovf_flags i=%0d got %b exp %b", i, {m_valid4, m_last4, done4}, {i >= 1 && i <= 4, i == 4, i == 4});
      end
      if (i >= 1 && i <= 4) begin
        tests++;
        if (m_data4 !== 8'hA0 + 8'(i - 1)) begin
          fails++;
          $display("FAIL ovf_data i=%0d got %h exp %h", i, m_data4, 8'hA0 + 8'(i - 1));
        end
      end
    end
    tests++;
    if ({crc_ok4, len_err4, frame_len4} !== {2'b01, 8'd4}) begin
      fails++;
      $display("FAIL ovf_status got ok=%b le=%b len=%0d exp 0 1 4", crc_ok4, len_err4, frame_len4);
    end
    send(8'h01, 1'b0);
    send(8'h07, 1'b1);
    tests++;
    if ({m_valid4, done4, m_data4, crc_ok4, len_err4, frame_len4} !== {2'b11, 8'h01, 2'b10, 8'd1}) begin
      fails++;
      $display("FAIL ovf_next got v=%b d=%b data=%h ok=%b le=%b len=%0d exp 1 1 01 1 0 1",
               m_valid4, done4, m_data4, crc_ok4, len_err4, frame_len4);
    end
  endtask

  task automatic test_async_reset;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    s_data = 8'h33;
    s_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({m_data, m_valid, m_last, done, crc_ok, len_err, frame_len, err_count} !== 37'd0) begin
      fails++;
      $display("FAIL async_reset got %h exp 0", {m_data, m_valid, m_last, done, crc_ok, len_err, frame_len, err_count});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    s_valid = 1'b0;
    tests++;
    if ({m_valid, done, err_count} !== 18'd0) begin
      fails++;
      $display("FAIL reset_hold got v=%b d=%b err=%0d exp 0 0 0", m_valid, done, err_count);
    end
    send(8'h01, 1'b0);
    send(8'h07, 1'b1);
    tests++;
    if ({done, crc_ok, frame_len, err_count} !== {2'b11, 8'd1, 16'd0}) begin
      fails++;
      $display("FAIL post_reset got d=%b ok=%b len=%0d err=%0d exp 1 1 1 0", done, crc_ok, frame_len, err_count);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 65534; i++) send(8'h55, 1'b1);
    tests++;
    if (err_count !== 16'hFFFE) begin
      fails++;
      $display("FAIL sat_pre got %h exp fffe", err_count);
    end
    send(8'h55, 1'b1);
    tests++;
    if (err_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL sat_reach got %h exp ffff", err_count);
    end
    send(8'h01, 1'b0);
    send(8'h06, 1'b1);
    tests++;
    if ({done, crc_ok, err_count} !== {2'b10, 16'hFFFF}) begin
      fails++;
      $display("FAIL sat_hold got d=%b ok=%b err=%h exp 1 0 ffff", done, crc_ok, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_runt();
    test_abort();
    test_overflow();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
